// File: rtl/lcomp_ch_scheduler.sv
// Round-robin scheduler sharing one Q1.15 compressor pipeline between N_CH channels.
// Optional LCOMP_SCHED_STATS_EN adds the o_issue_cnt issue counter.
module lcomp_ch_scheduler #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned W_TOTAL  = 16,
  parameter int unsigned PIPE_LAT = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic [N_CH-1:0]           i_valid,
  input  logic [N_CH*W_TOTAL-1:0]   i_data,
  output logic [N_CH-1:0]           o_ready,
  output logic                      o_comp_ce,
  output logic [W_TOTAL-1:0]        o_comp_data,
  input  logic                      i_comp_ce,
  input  logic [W_TOTAL-1:0]        i_comp_data,
  output logic [N_CH-1:0]           o_valid,
  output logic [W_TOTAL-1:0]        o_data,
  output logic                      o_busy,
  output logic                      o_err
`ifdef LCOMP_SCHED_STATS_EN
  ,
  output logic [15:0]               o_issue_cnt
`endif
);

  localparam int unsigned DEPTH = PIPE_LAT + 2;
  localparam int unsigned CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [N_CH-1:0]      hold_full_q, hold_full_d;
  logic [W_TOTAL-1:0]   hold_data_q [N_CH];
  logic [W_TOTAL-1:0]   hold_data_d [N_CH];
  logic [N_CH-1:0]      ready_q, ready_d;
  logic [CW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 ce_q, ce_d;
  logic [W_TOTAL-1:0]   cdata_q, cdata_d;
  logic [N_CH-1:0]      valid_q, valid_d;
  logic [W_TOTAL-1:0]   data_q, data_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        tag_mem_q [DEPTH];
  logic [CW-1:0]        tag_mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        count_q, count_d;

  logic                 grant;
  logic [CW-1:0]        grant_idx;
  logic                 push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // rr_ptr_q holds the first channel to search, i.e. last_grant+1 mod N_CH.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = 1'b0;
    grant_idx = '0;
    if ((state_q == RUN || state_q == DRAIN) && count_q != OW'(DEPTH)) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        idx = (32'(rr_ptr_q) + i) % N_CH;
        if (!grant && hold_full_q[CW'(idx)]) begin
          grant     = 1'b1;
          grant_idx = CW'(idx);
        end
      end
    end
  end

  assign push = grant;
  assign pop  = i_comp_ce && (count_q != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_enable) state_d = RUN;
      RUN:     if (!i_enable) state_d = DRAIN;
      DRAIN: begin
        if (i_enable)                                state_d = RUN;
        else if (hold_full_q == '0 && count_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (grant && grant_idx == CW'(c)) hold_full_d[c] = 1'b0;
      if (i_valid[c] && ready_q[c]) begin
        hold_full_d[c] = 1'b1;
        hold_data_d[c] = i_data[c*W_TOTAL +: W_TOTAL];
      end
    end

    // Ready looks at next-cycle occupancy so a just-filled register is not offered again.
    ready_d  = (state_d == RUN) ? ~hold_full_d : '0;
    ce_d     = grant;
    cdata_d  = grant ? hold_data_q[grant_idx] : cdata_q;
    rr_ptr_d = grant ? CW'((32'(grant_idx) + 1) % N_CH) : rr_ptr_q;

    tag_mem_d = tag_mem_q;
    if (push) tag_mem_d[wr_ptr_q] = grant_idx;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    valid_d = '0;
    data_d  = data_q;
    err_d   = err_q;
    if (i_comp_ce) begin
      if (count_q != '0) begin
        valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
        data_d = i_comp_data;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      hold_full_q <= '0;
      hold_data_q <= '{default: '0};
      ready_q     <= '0;
      rr_ptr_q    <= '0;
      ce_q        <= 1'b0;
      cdata_q     <= '0;
      valid_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      tag_mem_q   <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      ready_q     <= ready_d;
      rr_ptr_q    <= rr_ptr_d;
      ce_q        <= ce_d;
      cdata_q     <= cdata_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
      tag_mem_q   <= tag_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_comp_ce   = ce_q;
  assign o_comp_data = cdata_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != IDLE) || (count_q != '0);

`ifdef LCOMP_SCHED_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (grant && state_q != IDLE) issue_cnt_d = issue_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) issue_cnt_q <= '0;
    else            issue_cnt_q <= issue_cnt_d;
  end

  assign o_issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_lcomp_ch_scheduler.sv
// Directed bench for lcomp_ch_scheduler with a 5-cycle compressor stand-in (y = x - x/4).
module tb_lcomp_ch_scheduler;

  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [N_CH-1:0]   vin = '0;
  logic [N_CH*W-1:0] din = '0;
  logic [N_CH-1:0]   rdy;
  logic              cce;
  logic [W-1:0]      cdata;
  logic              rce;
  logic [W-1:0]      rdata;
  logic [N_CH-1:0]   ov;
  logic [W-1:0]      od;
  logic              busy;
  logic              err;
  logic              spur = 1'b0;
`ifdef LCOMP_SCHED_STATS_EN
  logic [15:0]       issue_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcomp_ch_scheduler #(.N_CH(N_CH), .W_TOTAL(W), .PIPE_LAT(5)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
    .i_valid(vin), .i_data(din), .o_ready(rdy),
    .o_comp_ce(cce), .o_comp_data(cdata),
    .i_comp_ce(rce), .i_comp_data(rdata),
    .o_valid(ov), .o_data(od), .o_busy(busy), .o_err(err)
`ifdef LCOMP_SCHED_STATS_EN
    , .o_issue_cnt(issue_cnt)
`endif
  );

  function automatic logic [15:0] f(input logic [15:0] x);
    logic signed [15:0] s;
    s = x;
    return 16'(s - (s >>> 2));
  endfunction

  logic [4:0]  m_ce;
  logic [15:0] m_d [5];
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ce <= '0;
    end else begin
      m_ce    <= {m_ce[3:0], cce};
      m_d[0]  <= f(cdata);
      for (int i = 1; i < 5; i++) m_d[i] <= m_d[i-1];
    end
  end
  assign rce   = m_ce[4] | spur;
  assign rdata = m_d[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  vin;
    logic [63:0] din;
    logic [3:0]  rdy;
    logic        ce;
    logic [15:0] cd;
    logic [3:0]  ov;
    logic [15:0] od;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [63:0] d, input logic [3:0] r,
                              input logic c, input logic [15:0] cd, input logic [3:0] o,
                              input logic [15:0] odv);
    vec_t t;
    t.vin = v; t.din = d; t.rdy = r; t.ce = c; t.cd = cd; t.ov = o; t.od = odv;
    return t;
  endfunction

  vec_t tbl [22];

  initial begin
    int n_iss, gap, got, done, ch;
    logic [15:0] prev, exp_d;

    // all four channels at once, then a single ch1 sample
    tbl[0]  = mk(4'b1111, 64'h4000_3000_2000_1000, 4'b1111, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0000, 64'h0, 4'b0000, 0, 0,        4'b0000, 0);
    tbl[2]  = mk(4'b0000, 64'h0, 4'b0001, 1, 16'h1000, 4'b0000, 0);
    tbl[3]  = mk(4'b0000, 64'h0, 4'b0011, 1, 16'h2000, 4'b0000, 0);
    tbl[4]  = mk(4'b0000, 64'h0, 4'b0111, 1, 16'h3000, 4'b0000, 0);
    tbl[5]  = mk(4'b0000, 64'h0, 4'b1111, 1, 16'h4000, 4'b0000, 0);
    tbl[6]  = mk(4'b0000, 64'h0, 4'b1111, 0, 0,        4'b0000, 0);
    tbl[7]  = mk(4'b0000, 64'h0, 4'b1111, 0, 0,        4'b0000, 0);
    tbl[8]  = mk(4'b0000, 64'h0, 4'b1111, 0, 0,        4'b0001, 16'h0C00);
    tbl[9]  = mk(4'b0000, 64'h0, 4'b1111, 0, 0,        4'b0010, 16'h1800);
    tbl[10] = mk(4'b0000, 64'h0, 4'b1111, 0, 0,        4'b0100, 16'h2400);
    tbl[11] = mk(4'b0000, 64'h0, 4'b1111, 0, 0,        4'b1000, 16'h3000);
    tbl[12] = mk(4'b0010, 64'h0000_0000_4000_0000, 4'b1111, 0, 0, 4'b0000, 0);
    tbl[13] = mk(4'b0000, 64'h0, 4'b1101, 0, 0,        4'b0000, 0);
    tbl[14] = mk(4'b0000, 64'h0, 4'b1111, 1, 16'h4000, 4'b0000, 0);
    for (int k = 15; k < 20; k++) tbl[k] = mk(4'b0000, 64'h0, 4'b1111, 0, 0, 4'b0000, 0);
    tbl[20] = mk(4'b0000, 64'h0, 4'b1111, 0, 0,        4'b0010, 16'h3000);
    tbl[21] = mk(4'b0000, 64'h0, 4'b1111, 0, 0,        4'b0000, 0);

    // reset state
    #1;
    chk("rst_ready", rdy, 0);
    chk("rst_ce", cce, 0);
    chk("rst_cdata", cdata, 0);
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_ready", rdy, 0);
    chk("idle_busy", busy, 0);

    enable = 1'b1;
    tick();
    chk("run_busy", busy, 1);

    for (int k = 0; k < 22; k++) begin
      chk($sformatf("tbl%0d_ready", k), rdy, tbl[k].rdy);
      chk($sformatf("tbl%0d_ce", k), cce, tbl[k].ce);
      if (tbl[k].ce) chk($sformatf("tbl%0d_cdata", k), cdata, tbl[k].cd);
      chk($sformatf("tbl%0d_valid", k), ov, tbl[k].ov);
      if (tbl[k].ov != 0) chk($sformatf("tbl%0d_data", k), od, tbl[k].od);
      chk($sformatf("tbl%0d_err", k), err, 0);
      vin = tbl[k].vin;
      din = tbl[k].din;
      tick();
    end

    // fairness: ch0 and ch2 permanently valid; search starts at ch2 after the ch1 grant
    vin = 4'b0101;
    din = 64'h0000_2222_0000_1111;
    n_iss = 0; gap = 0; prev = 16'h2222;
    for (int c = 0; c < 40 && n_iss < 8; c++) begin
      tick();
      gap++;
      if (cce) begin
        exp_d = (n_iss % 2 == 0) ? 16'h2222 : 16'h1111;
        chk($sformatf("fair_issue%0d", n_iss), cdata, exp_d);
        chk($sformatf("fair_gap%0d", n_iss), (gap <= N_CH), 1);
        n_iss++;
        gap = 0;
      end
    end
    chk("fair_count", n_iss, 8);
    vin = '0;
    repeat (15) tick();

    // drain with three samples held
    chk("pre_drain_ready", rdy, 4'b1111);
    vin = 4'b0111;
    din = 64'h0000_C000_1000_0800;
    tick();
    vin = '0;
    enable = 1'b0;
    got = 0; done = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 1) chk("drain_busy", busy, 1);
      chk($sformatf("drain_ready_t%0d", t), rdy, 0);
      if (ov != 0) begin
        chk($sformatf("drain_onehot%0d", got), $onehot(ov), 1);
        ch = 3;
        for (int i = 0; i < 3; i++) if (ov[i]) ch = i;
        case (ch)
          0:       exp_d = 16'h0600;
          1:       exp_d = 16'h0C00;
          2:       exp_d = 16'hD000;
          default: exp_d = 16'hDEAD;
        endcase
        chk($sformatf("drain_data%0d", got), od, exp_d);
        got++;
      end
      if (!busy) begin
        done = 1;
        break;
      end
    end
    chk("drain_done", done, 1);
    chk("drain_results", got, 3);
    chk("drain_err", err, 0);

    // spurious return with empty tag FIFO
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_valid", ov, 0);
    repeat (3) tick();
    chk("spur_err_sticky", err, 1);
    chk("spur_valid_late", ov, 0);
    rst_n = 1'b0;
    #1;
    chk("spur_err_cleared", err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

`ifdef LCOMP_SCHED_STATS_EN
    begin
      int n;
      n = 0;
      enable = 1'b1;
      vin = 4'b1111;
      din = 64'h0004_0003_0002_0001;
      for (int c = 0; c < 90000 && n < 70000; c++) begin
        tick();
        if (cce) n++;
      end
      vin = '0;
      enable = 1'b0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (cce) n++;
      end
      chk("stats_reached", (n >= 70000), 1);
      chk("stats_cnt", issue_cnt, 16'(n));
      repeat (5) tick();
      chk("stats_hold_idle", issue_cnt, 16'(n));
      rst_n = 1'b0;
      #1;
      chk("stats_reset", issue_cnt, 0);
      rst_n = 1'b1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
